// File: rtl/ahb_dataphase_ctrl_pkg.sv
// Shared constants, types and decode helper for the AHB data-phase controller.
package ahb_dataphase_ctrl_pkg;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned TRANS_W  = 2;
   localparam int unsigned SEL_W    = 3;
   localparam int unsigned REGION_W = 4;

   localparam logic [REGION_W-1:0] REGION_S1 = 4'h0;
   localparam logic [REGION_W-1:0] REGION_S2 = 4'h1;
   localparam logic [REGION_W-1:0] REGION_S3 = 4'h2;

   localparam logic [SEL_W-1:0] SEL_S1  = 3'b000;
   localparam logic [SEL_W-1:0] SEL_S2  = 3'b001;
   localparam logic [SEL_W-1:0] SEL_S3  = 3'b010;
   localparam logic [SEL_W-1:0] SEL_DEF = 3'b011;

   localparam logic [TRANS_W-1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [TRANS_W-1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [TRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [TRANS_W-1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } dslv_state_t;

   // Map the top address nibble to a slave select code.
   function automatic logic [SEL_W-1:0] decode_region(input logic [REGION_W-1:0] region);
      case (region)
         REGION_S1: decode_region = SEL_S1;
         REGION_S2: decode_region = SEL_S2;
         REGION_S3: decode_region = SEL_S3;
         default:   decode_region = SEL_DEF;
      endcase
   endfunction

endpackage

// File: rtl/ahb_dataphase_ctrl_if.sv
// Bus bundle between the AHB master/slaves and the data-phase controller.
interface ahb_dataphase_ctrl_if
   import ahb_dataphase_ctrl_pkg::*;
#(
   parameter int unsigned ERRCNT_W = 8
);
   logic [ADDR_W-1:0]  haddr;
   logic [TRANS_W-1:0] htrans;
   logic               hreadyout1, hreadyout2, hreadyout3;
   logic               hresp1, hresp2, hresp3;
   logic               hsel1, hsel2, hsel3;
   logic [SEL_W-1:0]   sel;
   logic               hready;
   logic               hresp;
   logic [ERRCNT_W-1:0] err_count;

   // Bus side: drives address phase and slave responses.
   modport master (
      output haddr, htrans, hreadyout1, hreadyout2, hreadyout3, hresp1, hresp2, hresp3,
      input  hsel1, hsel2, hsel3, sel, hready, hresp, err_count
   );

   // Controller side.
   modport slave (
      input  haddr, htrans, hreadyout1, hreadyout2, hreadyout3, hresp1, hresp2, hresp3,
      output hsel1, hsel2, hsel3, sel, hready, hresp, err_count
   );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR response for accepted transfers to unmapped space,
// plus a saturating count of completed error responses.
module ahb_default_slave
   import ahb_dataphase_ctrl_pkg::*;
#(
   parameter int unsigned ERRCNT_W = 8
) (
   input  logic                hclk,
   input  logic                hresetn,
   input  logic                start,
   output logic                ready,
   output logic                resp,
   output logic [ERRCNT_W-1:0] err_count
);

   localparam logic [ERRCNT_W-1:0] CNT_MAX = '1;

   dslv_state_t state;

   // Outputs are registered alongside the state so they change with it.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state     <= DS_IDLE;
         ready     <= 1'b1;
         resp      <= HRESP_OKAY;
         err_count <= '0;
      end else begin
         case (state)
            DS_IDLE: begin
               if (start) begin
                  state <= DS_ERR1;
                  ready <= 1'b0;
                  resp  <= HRESP_ERROR;
               end
            end
            DS_ERR1: begin
               state <= DS_ERR2;
               ready <= 1'b1;
               resp  <= HRESP_ERROR;
            end
            DS_ERR2: begin
               if (err_count != CNT_MAX) err_count <= err_count + ERRCNT_W'(1);
               if (start) begin
                  state <= DS_ERR1;
                  ready <= 1'b0;
                  resp  <= HRESP_ERROR;
               end else begin
                  state <= DS_IDLE;
                  ready <= 1'b1;
                  resp  <= HRESP_OKAY;
               end
            end
            default: begin
               state <= DS_IDLE;
               ready <= 1'b1;
               resp  <= HRESP_OKAY;
            end
         endcase
      end
   end

endmodule

// File: rtl/ahb_dataphase_ctrl.sv
// AHB address decode, registered data-phase select and ready/response multiplexer.
module ahb_dataphase_ctrl
   import ahb_dataphase_ctrl_pkg::*;
#(
   parameter int unsigned ERRCNT_W = 8
) (
   input logic                 hclk,
   input logic                 hresetn,
   ahb_dataphase_ctrl_if.slave bus
);

   logic [SEL_W-1:0]    dec_sel;
   logic [SEL_W-1:0]    sel_q;
   logic                hready_mux;
   logic                hresp_mux;
   logic                def_start;
   logic                def_ready;
   logic                def_resp;
   logic [ERRCNT_W-1:0] def_count;

   assign dec_sel  = decode_region(bus.haddr[ADDR_W-1 -: REGION_W]);
   assign bus.hsel1 = (dec_sel == SEL_S1);
   assign bus.hsel2 = (dec_sel == SEL_S2);
   assign bus.hsel3 = (dec_sel == SEL_S3);

   // Address-to-data pipeline: select advances only when the bus is ready.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn)        sel_q <= SEL_DEF;
      else if (hready_mux) sel_q <= dec_sel;
   end

   always_comb begin
      hready_mux = def_ready;
      hresp_mux  = def_resp;
      case (sel_q)
         SEL_S1: begin hready_mux = bus.hreadyout1; hresp_mux = bus.hresp1; end
         SEL_S2: begin hready_mux = bus.hreadyout2; hresp_mux = bus.hresp2; end
         SEL_S3: begin hready_mux = bus.hreadyout3; hresp_mux = bus.hresp3; end
         default: ;
      endcase
   end

   // Only an accepted NONSEQ/SEQ to unmapped space starts an error response.
   assign def_start = hready_mux && bus.htrans[1] && (dec_sel == SEL_DEF);

   ahb_default_slave #(.ERRCNT_W(ERRCNT_W)) u_default_slave (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .start     (def_start),
      .ready     (def_ready),
      .resp      (def_resp),
      .err_count (def_count)
   );

   assign bus.sel       = sel_q;
   assign bus.hready    = hready_mux;
   assign bus.hresp     = hresp_mux;
   assign bus.err_count = def_count;

endmodule

// File: tb/tb_ahb_dataphase_ctrl.sv
// Scoreboard bench for ahb_dataphase_ctrl: directed scenarios plus random traffic.
module tb_ahb_dataphase_ctrl;

   localparam int unsigned CW   = 8;
   localparam int          CMAX = 255;

   logic hclk;
   logic hresetn;

   ahb_dataphase_ctrl_if #(.ERRCNT_W(CW)) bus ();

   ahb_dataphase_ctrl #(.ERRCNT_W(CW)) dut (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   typedef struct {
      logic [2:0] hsel;
      logic [2:0] sel;
      logic       rdy;
      logic       rsp;
      int         cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   stim_done = 0;

   // Reference model: which slave owns the data phase (0 = unmapped), how far into
   // the two-cycle error response we are (0 none, 1 first, 2 second), and the count.
   int m_owner;
   int m_phase;
   int m_cnt;

   function automatic int owner_of(input logic [31:0] a);
      int r;
      r = int'(a[31:28]);
      if (r <= 2) return r + 1;
      return 0;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
      end
   endtask

   task automatic cyc(input logic [31:0] a, input logic [1:0] t,
                      input logic [2:0] ro, input logic [2:0] rs, input logic rn);
      exp_t e;
      int   own;
      bit   accepted;
      @(negedge hclk);
      hresetn         = rn;
      bus.haddr       = a;
      bus.htrans      = t;
      bus.hreadyout1  = ro[0];
      bus.hreadyout2  = ro[1];
      bus.hreadyout3  = ro[2];
      bus.hresp1      = rs[0];
      bus.hresp2      = rs[1];
      bus.hresp3      = rs[2];
      if (!rn) begin
         m_owner = 0;
         m_phase = 0;
         m_cnt   = 0;
      end
      own    = owner_of(a);
      e.hsel = 3'b000;
      if (own != 0) e.hsel[own-1] = 1'b1;
      e.sel  = (m_owner == 0) ? 3'd3 : 3'(m_owner - 1);
      if (m_owner != 0) begin
         e.rdy = ro[m_owner-1];
         e.rsp = rs[m_owner-1];
      end else begin
         e.rdy = (m_phase != 1);
         e.rsp = (m_phase != 0);
      end
      e.cnt = m_cnt;
      exp_q.push_back(e);
      if (rn) begin
         accepted = e.rdy;
         if (m_phase == 2 && m_cnt < CMAX) m_cnt++;
         if (accepted && t[1] && own == 0) m_phase = 1;
         else if (m_phase == 1)            m_phase = 2;
         else                              m_phase = 0;
         if (accepted) m_owner = own;
      end
   endtask

   // Monitor: compares the DUT against the oldest expectation each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge hclk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("hsel",      int'({bus.hsel3, bus.hsel2, bus.hsel1}), int'(e.hsel));
            check("sel",       int'(bus.sel),       int'(e.sel));
            check("hready",    int'(bus.hready),    int'(e.rdy));
            check("hresp",     int'(bus.hresp),     int'(e.rsp));
            check("err_count", int'(bus.err_count), e.cnt);
         end
      end
   end

   initial begin
      logic [31:0] a;
      logic [2:0]  ro;
      hresetn = 1'b0;
      bus.haddr = '0; bus.htrans = 2'b00;
      bus.hreadyout1 = 1'b1; bus.hreadyout2 = 1'b1; bus.hreadyout3 = 1'b1;
      bus.hresp1 = 1'b0; bus.hresp2 = 1'b0; bus.hresp3 = 1'b0;

      // Reset state
      cyc(32'h0, 2'b00, 3'b111, 3'b000, 1'b0);
      cyc(32'h0, 2'b00, 3'b111, 3'b000, 1'b0);

      // Pipelined reads to slave1 then slave2
      cyc(32'h0000_0010, 2'b10, 3'b111, 3'b000, 1'b1);
      cyc(32'h1000_0020, 2'b10, 3'b111, 3'b000, 1'b1);
      cyc(32'h0000_0000, 2'b00, 3'b111, 3'b000, 1'b1);

      // Slave3 wait states hold the pipeline
      cyc(32'h2000_0000, 2'b10, 3'b111, 3'b000, 1'b1);
      for (int i = 0; i < 3; i++) cyc(32'h0000_0040, 2'b10, 3'b011, 3'b000, 1'b1);
      cyc(32'h0000_0040, 2'b10, 3'b111, 3'b000, 1'b1);
      cyc(32'h0000_0000, 2'b00, 3'b111, 3'b000, 1'b1);

      // Unmapped NONSEQ, plus IDLE/BUSY to unmapped space
      cyc(32'h5000_0000, 2'b10, 3'b111, 3'b000, 1'b1);
      cyc(32'h5000_0000, 2'b00, 3'b111, 3'b000, 1'b1);
      cyc(32'h6000_0000, 2'b01, 3'b111, 3'b000, 1'b1);
      cyc(32'h0000_0000, 2'b00, 3'b111, 3'b000, 1'b1);

      // Back-to-back errors until the counter saturates
      for (int i = 0; i < 650; i++) cyc(32'hF000_0000, (i % 2 == 0) ? 2'b10 : 2'b11, 3'b111, 3'b000, 1'b1);
      cyc(32'h0000_0000, 2'b00, 3'b111, 3'b000, 1'b1);
      cyc(32'h0000_0000, 2'b00, 3'b111, 3'b000, 1'b1);

      // Reset pulse during ERR1 aborts the response
      cyc(32'h5000_0000, 2'b10, 3'b111, 3'b000, 1'b1);
      cyc(32'h5000_0000, 2'b00, 3'b111, 3'b000, 1'b0);
      cyc(32'h0000_0000, 2'b00, 3'b111, 3'b000, 1'b1);
      cyc(32'h0000_0000, 2'b00, 3'b111, 3'b000, 1'b1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         a  = {4'($urandom_range(0, 7)), 28'($urandom)};
         if ($urandom_range(0, 9) == 0) a[31:28] = 4'($urandom_range(8, 15));
         ro = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
         cyc(a, 2'($urandom), ro, 3'($urandom), ($urandom_range(0, 199) != 0));
      end
      cyc(32'h0, 2'b00, 3'b111, 3'b000, 1'b1);
      stim_done = 1;
   end

   initial begin
      fork
         wait (stim_done);
         begin
            #200000;
            $display("FAIL timeout at %0t: stimulus did not complete", $time);
            errors++;
         end
      join_any
      disable fork;
      @(negedge hclk);
      @(negedge hclk);
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
